mul_seq: RTL and testbench

//   Sequential shift-add multiplier, the inverse companion to the repeated-subtraction divider.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_step.sv | 18 +
 rtl/mul_seq.sv | 100 ++++++++++
 tb/tb_mul_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Provides the FSM state enum and the default operand width.
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1
    } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiplier step, purely combinational.
// Ports: acc/a_sh/b_sh in -> acc_nxt/a_sh_nxt/b_sh_nxt out.
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] a_sh,
    input  logic [WIDTH-1:0]   b_sh,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] a_sh_nxt,
    output logic [WIDTH-1:0]   b_sh_nxt
);

    assign acc_nxt  = b_sh[0] ? acc + a_sh : acc;
    assign a_sh_nxt = a_sh << 1;
    assign b_sh_nxt = b_sh >> 1;

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier; recomputes a*b whenever a or b changes.
// Ports: clk, rst_n, a, b in; product, overflow, valid, busy out.
// Build option: MUL_SATURATE_EN clamps product to all-ones on overflow.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic             valid,
    output logic             busy
);

    mul_state_t state;

    logic [WIDTH-1:0]   last_a;
    logic [WIDTH-1:0]   last_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_sh;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] a_sh_nxt;
    logic [WIDTH-1:0]   b_sh_nxt;

    logic             hi_any;
    logic [WIDTH-1:0] result;
    logic             changed;

    mul_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .a_sh    (a_sh),
        .b_sh    (b_sh),
        .acc_nxt (acc_nxt),
        .a_sh_nxt(a_sh_nxt),
        .b_sh_nxt(b_sh_nxt)
    );

    assign hi_any  = |acc[2*WIDTH-1:WIDTH];
    assign changed = (a != last_a) || (b != last_b);

`ifdef MUL_SATURATE_EN
    assign result = hi_any ? {WIDTH{1'b1}} : acc[WIDTH-1:0];
`else
    assign result = acc[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_a   <= '0;
            last_b   <= '0;
            acc      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            product  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (changed) begin
                        last_a <= a;
                        last_b <= b;
                        a_sh   <= {{WIDTH{1'b0}}, a};
                        b_sh   <= b;
                        acc    <= '0;
                        valid  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // Stop as soon as no multiplier bits remain.
                    if (b_sh != '0) begin
                        acc  <= acc_nxt;
                        a_sh <= a_sh_nxt;
                        b_sh <= b_sh_nxt;
                    end else begin
                        product  <= result;
                        overflow <= hi_any;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Randomized self-checking bench for mul_seq against an arithmetic model.
// Honors MUL_SATURATE_EN for the expected product.
module tb_mul_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] product;
    logic         overflow;
    logic         valid;
    logic         busy;

    int errs;
    int checks;

    mul_seq #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .product (product),
        .overflow(overflow),
        .valid   (valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++)
            if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [W-1:0] exp_prod(input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
`ifdef MUL_SATURATE_EN
        if (p[63:32] != 0) return '1;
`endif
        return p[W-1:0];
    endfunction

    function automatic logic exp_ovf(input logic [W-1:0] x,
                                     input logic [W-1:0] y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
        return p[63:32] != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for completion after E0; returns edges counted after E0.
    task automatic wait_done(output int n);
        n = 0;
        while (!valid && n < W + 4) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        int n;
        a = x;
        b = y;
        tick();
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_valid"}, valid, 0);
        wait_done(n);
        check({tag, "_lat"}, n, bitlen(y) + 1);
        check({tag, "_prod"}, product, exp_prod(x, y));
        check({tag, "_ovf"}, overflow, exp_ovf(x, y));
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        errs   = 0;
        checks = 0;
        a      = '0;
        b      = '0;
        rst_n  = 1'b0;
        #12;
        check("rst_prod", product, 0);
        check("rst_valid", valid, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) tick();
        check("zero_prod", product, 0);
        check("zero_valid", valid, 1);
        check("zero_busy", busy, 0);

        run_op("t440x3", 32'd440, 32'd3);
        run_op("t7x0", 32'd7, 32'd0);
        run_op("tovf", 32'h10000, 32'h10000);
        run_op("t0x9", 32'd0, 32'd9);

        // Same operands: no new operation.
        tick();
        check("same_busy", busy, 0);
        check("same_valid", valid, 1);

        // Change then revert before an edge: no operation.
        b = 32'd1234;
        #2;
        b = 32'd9;
        tick();
        check("revert_busy", busy, 0);
        check("revert_prod", product, 0);

        // Operand change during CALC.
        run_op("t100x1", 32'd100, 32'd1);
        a = 32'd100;
        b = 32'd5;
        tick();
        check("chg_start", busy, 1);
        b = 32'd9;
        wait_done(n);
        check("chg_lat", n, 4);
        check("chg_prod1", product, 500);
        tick();
        check("chg_pulse_valid", valid, 0);
        check("chg_pulse_busy", busy, 1);
        wait_done(n);
        check("chg_lat2", n, 5);
        check("chg_prod2", product, 900);

        // Reset in the middle of a calculation.
        a = 32'd100;
        b = 32'hFF;
        tick();
        tick();
        tick();
        check("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_prod", product, 0);
        check("mid_rst_valid", valid, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", overflow, 0);
        #3;
        rst_n = 1'b1;
        tick();
        check("rerun_busy", busy, 1);
        wait_done(n);
        check("rerun_lat", n, 9);
        check("rerun_prod", product, 25500);

        // Randomized operations with varied multiplier bit-lengths.
        pa = a;
        pb = b;
        for (int i = 0; i < 30; i++) begin
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 31);
            if (i % 7 == 3) ra = '0;
            if (ra == pa && rb == pb) rb = rb + 1;
            run_op($sformatf("rnd%0d", i), ra, rb);
            pa = ra;
            pb = rb;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
